// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit driving a req/ack data bus with byte-lane handling and pipeline stall.
module mem_access #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_sdata_i,
  input  logic        mem_wreg_en_i,
  input  logic [4:0]  mem_wreg_addr_i,
  input  logic [31:0] mem_wreg_data_i,
  output logic        mem_wreg_en_o,
  output logic [4:0]  mem_wreg_addr_o,
  output logic [31:0] mem_wreg_data_o,
  output logic        mem_stallreq,
  output logic        mem_bus_err_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic        req, we, tmo;
  logic [31:0] addr, wdata, ldata;
  logic [3:0]  be;
  logic [7:0]  cnt;
  logic        is_lb, is_lw, is_sb, is_sw, is_ld, is_mem, misal, valid, ack, expire;
  logic [7:0]  lane;
  assign is_lb  = mem_op_i == 3'd1;
  assign is_lw  = mem_op_i == 3'd2;
  assign is_sb  = mem_op_i == 3'd3;
  assign is_sw  = mem_op_i == 3'd4;
  assign is_ld  = is_lb | is_lw;
  assign is_mem = is_ld | is_sb | is_sw;
  assign misal  = (is_lw | is_sw) & (|mem_addr_i[1:0]);
  assign valid  = is_mem & ~misal;
  assign ack    = (state == BUSY) & req & dbus_ack_i;
  // ack on the final allowed cycle takes priority over the timeout
  assign expire = (state == BUSY) & ~dbus_ack_i & (cnt == 8'(ACK_TIMEOUT - 1));
  assign lane   = dbus_rdata_i[{mem_addr_i[1:0], 3'b000} +: 8];
  always_comb begin
    state_n = state == IDLE ? (valid ? BUSY : IDLE) :
              state == BUSY ? ((ack | expire) ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req   <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      be    <= '0;
      wdata <= '0;
      cnt   <= '0;
      ldata <= '0;
      tmo   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && valid) begin
        req   <= 1'b1;
        we    <= is_sb | is_sw;
        addr  <= {mem_addr_i[31:2], 2'b00};
        be    <= is_sb ? 4'b0001 << mem_addr_i[1:0] : 4'hF;
        wdata <= is_sb ? {4{mem_sdata_i[7:0]}} : is_sw ? mem_sdata_i : '0;
        cnt   <= '0;
        tmo   <= 1'b0;
      end
      if (state == BUSY) begin
        cnt <= cnt + 8'd1;
        tmo <= expire;
        if (ack | expire) req <= 1'b0;
        if (ack) ldata <= is_lb ? {{24{lane[7]}}, lane} : dbus_rdata_i;
      end
    end
  end
  always_comb begin
    mem_wreg_en_o   = ~rst & (state == IDLE ? mem_wreg_en_i & ~is_mem :
                              state == DONE ? mem_wreg_en_i & ~(is_ld & tmo) : 1'b0);
    mem_wreg_addr_o = rst ? '0 : mem_wreg_addr_i;
    mem_wreg_data_o = rst ? '0 : (state == DONE && is_ld) ? ldata : mem_wreg_data_i;
    mem_stallreq    = ~rst & (state == BUSY | (state == IDLE & valid));
    mem_bus_err_o   = ~rst & ((state == IDLE & misal) | (state == DONE & tmo));
    dbus_req_o      = ~rst & req;
    dbus_we_o       = ~rst & we;
    dbus_addr_o     = rst ? '0 : addr;
    dbus_be_o       = rst ? '0 : be;
    dbus_wdata_o    = rst ? '0 : wdata;
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a transaction-level reference model.
module tb_mem_access;
  logic        clk = 0, rst = 1;
  logic [2:0]  op = 0;
  logic [31:0] maddr = 0, sdata = 0, wd = 0, rdata = 0;
  logic        wen = 0, ack = 0;
  logic [4:0]  wa = 0;
  logic        en_o, stall, err, req, we;
  logic [4:0]  wa_o;
  logic [31:0] wd_o, baddr, bwdata;
  logic [3:0]  be;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mem_access #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .mem_op_i(op), .mem_addr_i(maddr), .mem_sdata_i(sdata),
    .mem_wreg_en_i(wen), .mem_wreg_addr_i(wa), .mem_wreg_data_i(wd),
    .mem_wreg_en_o(en_o), .mem_wreg_addr_o(wa_o), .mem_wreg_data_o(wd_o),
    .mem_stallreq(stall), .mem_bus_err_o(err), .dbus_req_o(req), .dbus_we_o(we),
    .dbus_addr_o(baddr), .dbus_be_o(be), .dbus_wdata_o(bwdata),
    .dbus_rdata_i(rdata), .dbus_ack_i(ack)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic samp;
    @(negedge clk);
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_en"}, 32'(en_o), 0);
    chk({tag, "_wa"}, 32'(wa_o), 0);
    chk({tag, "_wd"}, wd_o, 0);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_req"}, 32'(req), 0);
    chk({tag, "_we"}, 32'(we), 0);
    chk({tag, "_addr"}, baddr, 0);
    chk({tag, "_be"}, 32'(be), 0);
    chk({tag, "_wdata"}, bwdata, 0);
  endtask
  // One instruction through MEM; dly = BUSY cycle index of the ack, >=15 means never.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] sd,
                     input logic e, input logic [4:0] r, input logic [31:0] d,
                     input int dly, input logic [31:0] rd);
    bit ld, st, mis, to;
    logic [31:0] lres, bexp, wexp, b;
    ld  = (o == 1) || (o == 2);
    st  = (o == 3) || (o == 4);
    mis = ((o == 2) || (o == 4)) && (a % 4 != 0);
    to  = dly >= 15;
    b   = (rd >> (8 * (a % 4))) % 256;
    lres = (o == 1) ? (b >= 128 ? b + 32'hFFFFFF00 : b) : rd;
    bexp = (o == 3) ? (32'd1 << (a % 4)) : 32'd15;
    wexp = (o == 3) ? (sd % 256) * 32'h01010101 : sd;
    op = o; maddr = a; sdata = sd; wen = e; wa = r; wd = d; ack = 0; rdata = $urandom;
    if (!(ld || st) || mis) begin
      ack = 1'($urandom_range(0, 1));
      samp;
      chk("pass_stall", 32'(stall), 0);
      chk("pass_en", 32'(en_o), (ld || st) ? 0 : 32'(e));
      chk("pass_wa", 32'(wa_o), 32'(r));
      chk("pass_wd", wd_o, d);
      chk("pass_err", 32'(err), 32'(mis));
      chk("pass_req", 32'(req), 0);
      tick;
      ack = 0;
      return;
    end
    samp;
    chk("idle_stall", 32'(stall), 1);
    chk("idle_en", 32'(en_o), 0);
    chk("idle_req", 32'(req), 0);
    tick;
    for (int k = 0; k < 15; k++) begin
      if (k == dly) begin ack = 1; rdata = rd; end
      samp;
      chk("busy_req", 32'(req), 1);
      chk("busy_stall", 32'(stall), 1);
      chk("busy_en", 32'(en_o), 0);
      chk("busy_err", 32'(err), 0);
      chk("busy_we", 32'(we), 32'(st));
      chk("busy_addr", baddr, a & 32'hFFFFFFFC);
      chk("busy_be", 32'(be), bexp);
      if (st) chk("busy_wdata", bwdata, wexp);
      tick;
      ack = 0;
      rdata = $urandom;
      if (k == dly) break;
    end
    samp;
    chk("done_stall", 32'(stall), 0);
    chk("done_err", 32'(err), 32'(to));
    chk("done_req", 32'(req), 0);
    chk("done_en", 32'(en_o), 32'(ld ? (e && !to) : e));
    if (st) chk("done_wd", wd_o, d);
    else if (!to) chk("done_ld", wd_o, lres);
    tick;
  endtask
  initial begin
    op = 2; maddr = 32'h104; sdata = 32'h55; wen = 1; wa = 5'd7; wd = 32'h1234; ack = 1; rdata = 32'hFFFF;
    samp;
    all_zero("rst");
    tick;
    rst = 0; op = 0; ack = 0;
    run(3'd2, 32'h100, 0, 1, 5'd3, 32'h9, 0, 32'hDEADBEEF);
    run(3'd1, 32'h103, 0, 1, 5'd4, 32'h9, 0, 32'h80FF1234);
    run(3'd1, 32'h101, 0, 1, 5'd4, 32'h9, 2, 32'h80FF1234);
    run(3'd3, 32'h202, 32'h000000AB, 0, 5'd0, 32'h77, 1, 0);
    run(3'd4, 32'h006, 32'h11223344, 1, 5'd2, 32'h5, 0, 0);
    run(3'd2, 32'h300, 0, 1, 5'd9, 32'h5, 99, 32'h1);
    run(3'd2, 32'h304, 0, 1, 5'd9, 32'h5, 14, 32'hCAFEF00D);
    run(3'd4, 32'h400, 32'hA5A5_5A5A, 0, 5'd1, 32'h66, 99, 0);
    run(3'd6, 32'h401, 0, 1, 5'd31, 32'hFEED, 0, 0);
    op = 2; maddr = 32'h40; wen = 1; wa = 5'd5; wd = 32'h1;
    samp;
    tick;
    samp;
    chk("mid_req", 32'(req), 1);
    tick;
    rst = 1;
    samp;
    all_zero("mid_rst");
    tick;
    rst = 0; op = 0; ack = 1; rdata = 32'h12345678;
    samp;
    chk("post_req", 32'(req), 0);
    chk("post_stall", 32'(stall), 0);
    chk("post_err", 32'(err), 0);
    chk("post_en", 32'(en_o), 1);
    chk("post_wd", wd_o, 32'h1);
    tick;
    ack = 0;
    for (int i = 0; i < 80; i++) begin
      logic [2:0] o;
      int dl;
      o  = 3'($urandom_range(0, 7));
      dl = ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 14));
      run(o, $urandom, $urandom, 1'($urandom), 5'($urandom), $urandom, dl, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
